// File: rtl/ddr_to_pkts.sv
// ============================================================================
// ddr_to_pkts : credit-gated DDR3 read-return gatherer that emits one NoC
//               reply packet per read burst, tagged with its frame ID.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ddr_to_pkts #(
    parameter int AVL_DATA_WIDTH = 512,
    parameter int FRAME_ID_WIDTH = 32,
    parameter int BURST_LEN      = 8,
    parameter int FIFO_DEPTH     = 32,
    parameter int ID_DEPTH       = FIFO_DEPTH / BURST_LEN,
    parameter int WIDTH_PKT      = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_cmd_valid,
    input  logic [FRAME_ID_WIDTH-1:0] rd_cmd_id,
    output logic                      rd_cmd_ready,
    input  logic [AVL_DATA_WIDTH-1:0] avl_readdata,
    input  logic                      avl_readdatavalid,
    output logic [WIDTH_PKT-1:0]      noc_data_out,
    output logic [3:0]                noc_valid_out,
    output logic [3:0]                noc_sop_out,
    output logic [3:0]                noc_eop_out,
    input  logic                      noc_ready_in,
    output logic                      err_overflow,
    output logic                      err_unexpected
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int IW  = $clog2(ID_DEPTH);
    localparam int BW  = $clog2(BURST_LEN);
    localparam int CW  = AW + 1;
    localparam int ICW = IW + 1;

    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  BURST_C = CW'(BURST_LEN);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [ICW-1:0] IDD_C   = ICW'(ID_DEPTH);
    localparam logic [ICW-1:0] IONE_C  = ICW'(1);
    localparam logic [BW-1:0]  LAST_C  = BW'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [AVL_DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [FRAME_ID_WIDTH-1:0] id_mem   [ID_DEPTH];

    logic [CW-1:0]  data_wr_ptr, data_rd_ptr, data_count;
    logic [ICW-1:0] id_wr_ptr, id_rd_ptr, id_count;
    logic [CW-1:0]  reserved, outstanding, free_cnt;
    logic [BW-1:0]  beat_cnt;
    state_t         state;

    logic data_empty, data_full, id_empty, id_full;
    logic cmd_accept, word_expected, data_push, have_word, xfer, last_beat, pkt_done;

    assign data_count = data_wr_ptr - data_rd_ptr;
    assign id_count   = id_wr_ptr - id_rd_ptr;
    assign data_empty = (data_count == '0);
    assign data_full  = (data_count == DEPTH_C);
    assign id_empty   = (id_count == '0);
    assign id_full    = (id_count == IDD_C);
    assign free_cnt   = DEPTH_C - reserved;

    // A burst may only issue when its whole data payload already has a home.
    assign rd_cmd_ready  = !rst && (free_cnt >= BURST_C) && !id_full;
    assign cmd_accept    = rd_cmd_valid && rd_cmd_ready;
    assign word_expected = (outstanding != '0);
    assign data_push     = avl_readdatavalid && word_expected && !data_full;

    assign have_word = (state == SEND) && !data_empty;
    assign xfer      = have_word && noc_ready_in;
    assign last_beat = (beat_cnt == LAST_C);
    assign pkt_done  = xfer && last_beat;

    assign noc_valid_out = have_word ? 4'b1111 : 4'b0000;
    assign noc_sop_out   = (have_word && (beat_cnt == '0)) ? 4'b1000 : 4'b0000;
    assign noc_eop_out   = (have_word && last_beat) ? 4'b0001 : 4'b0000;
    assign noc_data_out  = {2'b00, id_mem[id_rd_ptr[IW-1:0]], data_mem[data_rd_ptr[AW-1:0]]};

    always_ff @(posedge clk) begin
        if (data_push) begin
            data_mem[data_wr_ptr[AW-1:0]] <= avl_readdata;
        end
        if (cmd_accept) begin
            id_mem[id_wr_ptr[IW-1:0]] <= rd_cmd_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr_ptr    <= '0;
            data_rd_ptr    <= '0;
            id_wr_ptr      <= '0;
            id_rd_ptr      <= '0;
            reserved       <= '0;
            outstanding    <= '0;
            beat_cnt       <= '0;
            state          <= IDLE;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (data_push) data_wr_ptr <= data_wr_ptr + ONE_C;
            if (xfer)      data_rd_ptr <= data_rd_ptr + ONE_C;
            if (cmd_accept) id_wr_ptr  <= id_wr_ptr + IONE_C;
            if (pkt_done)   id_rd_ptr  <= id_rd_ptr + IONE_C;

            reserved <= reserved + (cmd_accept ? BURST_C : '0) - (xfer ? ONE_C : '0);
            outstanding <= outstanding + (cmd_accept ? BURST_C : '0)
                         - ((avl_readdatavalid && word_expected) ? ONE_C : '0);

            if (avl_readdatavalid && !word_expected) err_unexpected <= 1'b1;
            if (avl_readdatavalid && word_expected && data_full) err_overflow <= 1'b1;

            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (!id_empty) state <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            // Chain straight into the next packet when one is queued.
                            state <= ((id_count > IONE_C) || cmd_accept) ? SEND : IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_to_pkts.sv
// Testbench for ddr_to_pkts: directed scenarios plus a random phase against a
// queue-based reference of accepted bursts and stored words.
`default_nettype none
`timescale 1ns/1ps

module tb_ddr_to_pkts;

    localparam int DW    = 512;
    localparam int IDW   = 32;
    localparam int BL    = 8;
    localparam int DEPTH = 32;
    localparam int IDD   = DEPTH / BL;
    localparam int PW    = DW + 2 + IDW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rd_cmd_valid = 1'b0;
    logic [IDW-1:0]  rd_cmd_id = '0;
    logic            rd_cmd_ready;
    logic [DW-1:0]   avl_readdata = '0;
    logic            avl_readdatavalid = 1'b0;
    logic [PW-1:0]   noc_data_out;
    logic [3:0]      noc_valid_out, noc_sop_out, noc_eop_out;
    logic            noc_ready_in = 1'b0;
    logic            err_overflow, err_unexpected;

    always #5 clk = ~clk;

    ddr_to_pkts #(
        .AVL_DATA_WIDTH(DW), .FRAME_ID_WIDTH(IDW), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_id(rd_cmd_id), .rd_cmd_ready(rd_cmd_ready),
        .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
        .noc_data_out(noc_data_out), .noc_valid_out(noc_valid_out),
        .noc_sop_out(noc_sop_out), .noc_eop_out(noc_eop_out), .noc_ready_in(noc_ready_in),
        .err_overflow(err_overflow), .err_unexpected(err_unexpected)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  d;
        int             beat;
    } word_t;

    word_t          stored[$];
    logic [IDW-1:0] data_ids[$];
    int data_beat = 0, m_res = 0, m_out = 0, pkts = 0;
    bit m_unexp = 0, m_ovf = 0;
    int n_pass = 0, n_checks = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_clear();
        stored.delete();
        data_ids.delete();
        data_beat = 0; m_res = 0; m_out = 0; pkts = 0; m_unexp = 0; m_ovf = 0;
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic cyc(input logic r, input logic cv, input logic [IDW-1:0] id,
                       input logic dv, input logic [DW-1:0] d, input logic rdy);
        bit ev, er, acc;
        word_t w;
        @(negedge clk);
        rst = r; rd_cmd_valid = cv; rd_cmd_id = id;
        avl_readdatavalid = dv; avl_readdata = d; noc_ready_in = rdy;
        #1;
        if (r) begin
            chk("rd_cmd_ready_in_rst", PW'(rd_cmd_ready), '0);
            model_clear();
        end else begin
            ev = (stored.size() > 0);
            er = ((DEPTH - m_res) >= BL) && (pkts < IDD);
            chk("rd_cmd_ready", PW'(rd_cmd_ready), PW'(er));
            chk("reserved", PW'(dut.reserved), PW'(m_res));
            chk("noc_valid", PW'(noc_valid_out), ev ? PW'(4'b1111) : PW'(4'b0000));
            chk("err_unexpected", PW'(err_unexpected), PW'(m_unexp));
            chk("err_overflow", PW'(err_overflow), PW'(m_ovf));
            if (ev) begin
                w = stored[0];
                chk("noc_data", noc_data_out, {2'b00, w.id, w.d});
                chk("sop", PW'(noc_sop_out), (w.beat == 0) ? PW'(4'b1000) : PW'(4'b0000));
                chk("eop", PW'(noc_eop_out), (w.beat == BL - 1) ? PW'(4'b0001) : PW'(4'b0000));
            end else begin
                chk("sop_idle", PW'(noc_sop_out), '0);
                chk("eop_idle", PW'(noc_eop_out), '0);
            end
            acc = cv && er;
            if (dv) begin
                if (m_out == 0) begin
                    m_unexp = 1;
                end else begin
                    if (stored.size() >= DEPTH) m_ovf = 1;
                    else stored.push_back('{id: data_ids[0], d: d, beat: data_beat});
                    m_out--;
                    data_beat++;
                    if (data_beat == BL) begin
                        data_beat = 0;
                        void'(data_ids.pop_front());
                    end
                end
            end
            if (ev && rdy) begin
                w = stored.pop_front();
                m_res--;
                if (w.beat == BL - 1) pkts--;
            end
            if (acc) begin
                data_ids.push_back(id);
                pkts++;
                m_res += BL;
                m_out += BL;
            end
        end
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic cmd(input logic [IDW-1:0] id, input logic rdy);
        cyc(1'b0, 1'b1, id, 1'b0, '0, rdy);
    endtask

    task automatic word(input logic rdy);
        cyc(1'b0, 1'b0, '0, 1'b1, rand_word(), rdy);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, (m_out > 0), rand_word(), 1'b1);
    endtask

    initial begin
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1'b1);

        // Single burst, ready always high.
        cmd(32'h1000_0005, 1'b1);
        for (int i = 0; i < BL; i++) word(1'b1);
        drain(4);

        // Four bursts fill every credit; one transfer leaves free=1, eight restore a credit.
        for (int i = 0; i < 4; i++) cmd($urandom, 1'b0);
        cmd($urandom, 1'b0);
        for (int i = 0; i < 4 * BL; i++) word(1'b0);
        idle(1'b1);
        idle(1'b0);
        for (int i = 0; i < 7; i++) idle(1'b1);
        idle(1'b0);
        drain(30);

        // Two bursts stored while stalled, then released back-to-back.
        cmd($urandom, 1'b0);
        cmd($urandom, 1'b0);
        for (int i = 0; i < 2 * BL; i++) word(1'b0);
        drain(20);

        // Accept and transfer in the same cycle with reserved=8.
        cmd($urandom, 1'b0);
        for (int i = 0; i < BL; i++) word(1'b0);
        cmd($urandom, 1'b1);
        @(posedge clk); #1;
        chk("accept_and_xfer_reserved", PW'(dut.reserved), PW'(15));
        drain(25);

        // Read data with nothing outstanding.
        word(1'b1);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);

        // Reset after three words of a packet; the rest of the burst is unexpected.
        cmd($urandom, 1'b1);
        for (int i = 0; i < 3; i++) word(1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1, rand_word(), 1'b1);
        for (int i = 0; i < 4; i++) word(1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, ($urandom_range(2) == 0), $urandom,
                (m_out > 0) && ($urandom_range(3) != 0), rand_word(),
                ($urandom_range(3) != 0));
        end
        drain(80);
        chk("all_words_delivered", PW'(stored.size()), '0);
        chk("no_packets_pending", PW'(pkts), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
